spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WIN_BASE, default 16, meaning the shortest counting window in clock cycles; it is a power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-004 SHALL have port spike_in, input, 1 bit, one spike per high cycle; it is synchronous to clk, e.g. the neuron spike output.
REQ-005 SHALL have port en, input, 1 bit, the decode enable.
REQ-006 SHALL have port win_sel, input, 2 bits, the window length: WIN_BASE << win_sel, i.e. 16, 32, 64 or 128 cycles at the default.
REQ-007 SHALL have port rate, output, 8 bits, the spike count of the last completed window.
REQ-008 SHALL have port out_valid, output, 1 bit, indicating that rate holds an untransferred result.
REQ-009 SHALL have port out_ready, input, 1 bit, the consumer accept.
REQ-010 SHALL have port isi, output, 8 bits, the last inter-spike interval in cycles.
REQ-011 SHALL have port isi_valid, output, 1 bit, a one-cycle pulse when isi updates.
REQ-012 SHALL have port overrun, output, 1 bit, a sticky flag indicating that a result was overwritten before transfer.
REQ-013 SHALL have port busy, output, 1 bit, high while in COUNT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and COUNT.
REQ-015 In IDLE with en=1, the FSM SHALL move to COUNT next cycle, latch win_sel, and clear the cycle counter, spike counter and ISI tracking. spike_in SHALL be ignored in IDLE, including during this transition cycle.
REQ-016 In COUNT with en=0, the FSM SHALL move to IDLE next cycle and discard the partial window with no result; a spike in that cycle SHALL NOT be counted.
REQ-017 In COUNT, the cycle counter SHALL increment each cycle, and the spike counter SHALL increment on spike_in=1, saturating at 255.
REQ-018 The window end is the COUNT cycle where cycle counter = window_len-1. At the window end the block SHALL do all of the following:
- load rate with the spike count including that cycle's spike;
- clear both counters;
- re-latch win_sel;
- set out_valid.
Windows SHALL run back to back with no gap cycles.
REQ-019 Latency: rate and out_valid SHALL be visible the cycle after the window-end edge.
REQ-020 Handshake: a transfer occurs on an edge where out_valid=1 and out_ready=1; out_valid SHALL then clear unless a new result loads on the same edge, in which case it stays 1 with the new rate.
REQ-021 rate SHALL hold stable while out_valid=1 and no new result is loaded.
REQ-022 If a window ends while out_valid=1 and out_ready=0, rate SHALL be overwritten and overrun SHALL set; overrun clears only on rst.
REQ-023 The ISI gap counter SHALL increment each COUNT cycle, saturating at 255, and reload to 1 on every counted spike.
REQ-024 On a counted spike with a prior spike in the same COUNT session, isi SHALL load the gap counter and isi_valid SHALL pulse for one cycle. The first spike of a session SHALL produce no isi_valid.
REQ-025 Consecutive-cycle spikes SHALL give isi=1, and gaps of 255 cycles or more SHALL give isi=255.
REQ-026 ISI tracking SHALL continue across window boundaries and SHALL reset only on entry to COUNT from IDLE.
REQ-027 win_sel changes mid-window SHALL have no effect until the next window boundary.

Reset
REQ-028 On rst=1 at an edge, the block SHALL:
- enter IDLE;
- set rate=0, out_valid=0, isi=0, isi_valid=0, overrun=0, busy=0;
- clear all counters and ISI history.
rst SHALL override en, spike_in and out_ready.
REQ-029 Reset mid-window SHALL discard the window with no result emitted, and the cleared state SHALL take effect the cycle after the reset edge.

Verification
REQ-030 Steady rate: WIN_BASE=16, win_sel=0, out_ready=1, spike every 4th COUNT cycle -> rate=4 with a one-cycle out_valid every 16 cycles, and isi=4 pulses after the first spike.
REQ-031 Saturation: win_sel=3, spike_in held at 1 -> rate=128. Separately, with WIN_BASE=256 and spike_in held at 1 -> rate=255, not wrapped.
REQ-032 Backpressure: out_ready=0 across two window ends with 3 then 5 spikes -> rate=5, out_valid=1, overrun=1. Raising out_ready -> one transfer, then out_valid=0.
REQ-033 Abort: en dropped at cycle 10 of a 16-cycle window after 2 spikes -> no out_valid. Re-enabling gives a fresh window counting from 0, and its first spike gives no isi_valid.
REQ-034 ISI edges: spikes 1 cycle apart -> isi=1; spikes 300 cycles apart across windows -> isi=255.
REQ-035 Reset mid-window: rst pulsed with out_valid=1 and overrun=1 -> all outputs 0 the next cycle, and no stale result is emitted afterwards.

Source files
------------

// File: rtl/spike_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spike_rate_decoder : windowed spike-rate counter with inter-spike interval
// Rev 1.0
// ============================================================================
module spike_rate_decoder #(
    parameter int WIN_BASE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spike_in,
    input  logic       en,
    input  logic [1:0] win_sel,
    output logic [7:0] rate,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] isi,
    output logic       isi_valid,
    output logic       overrun,
    output logic       busy
);

    // Cycle counter must reach (WIN_BASE << 3) - 1.
    localparam int CW = $clog2(WIN_BASE) + 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     win_sel_q, win_sel_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [7:0]     spk_q, spk_d;
    logic [7:0]     gap_q, gap_d;
    logic           seen_q, seen_d;
    logic [7:0]     rate_q, rate_d;
    logic           out_valid_q, out_valid_d;
    logic [7:0]     isi_q, isi_d;
    logic           isi_valid_q, isi_valid_d;
    logic           overrun_q, overrun_d;

    logic [CW:0]    win_len;
    logic [CW-1:0]  win_last;
    logic [7:0]     spk_nxt;
    logic           load;

    always_comb begin
        win_len  = (CW+1)'(WIN_BASE) << win_sel_q;
        win_last = CW'(win_len - (CW+1)'(1));
    end

    always_comb begin
        state_d     = state_q;
        win_sel_d   = win_sel_q;
        cyc_d       = cyc_q;
        spk_d       = spk_q;
        gap_d       = gap_q;
        seen_d      = seen_q;
        rate_d      = rate_q;
        isi_d       = isi_q;
        isi_valid_d = 1'b0;
        spk_nxt     = spk_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = COUNT;
                    win_sel_d = win_sel;
                    cyc_d     = '0;
                    spk_d     = '0;
                    gap_d     = '0;
                    seen_d    = 1'b0;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    spk_nxt = (spike_in && spk_q != 8'hFF) ? spk_q + 8'd1 : spk_q;
                    gap_d   = spike_in ? 8'd1 : ((gap_q == 8'hFF) ? gap_q : gap_q + 8'd1);
                    if (spike_in) begin
                        seen_d = 1'b1;
                        // The session's first spike only arms the interval tracker.
                        if (seen_q) begin
                            isi_d       = gap_q;
                            isi_valid_d = 1'b1;
                        end
                    end
                    if (cyc_q == win_last) begin
                        load      = 1'b1;
                        rate_d    = spk_nxt;
                        cyc_d     = '0;
                        spk_d     = '0;
                        win_sel_d = win_sel;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                        spk_d = spk_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh result keeps valid high even on a transfer edge.
        out_valid_d = load | (out_valid_q & ~out_ready);
        overrun_d   = overrun_q | (load & out_valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_sel_q   <= '0;
            cyc_q       <= '0;
            spk_q       <= '0;
            gap_q       <= '0;
            seen_q      <= 1'b0;
            rate_q      <= '0;
            out_valid_q <= 1'b0;
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_sel_q   <= win_sel_d;
            cyc_q       <= cyc_d;
            spk_q       <= spk_d;
            gap_q       <= gap_d;
            seen_q      <= seen_d;
            rate_q      <= rate_d;
            out_valid_q <= out_valid_d;
            isi_q       <= isi_d;
            isi_valid_q <= isi_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rate      = rate_q;
    assign out_valid = out_valid_q;
    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == COUNT);

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spike_rate_decoder : scoreboard bench for spike_rate_decoder
// Rev 1.0
// ============================================================================
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst, spike_in, en, out_ready;
    logic [1:0] win_sel;
    logic [7:0] rate, isi;
    logic       out_valid, isi_valid, overrun, busy;

    logic       b_en, b_spike, b_out_ready;
    logic [7:0] b_rate, b_isi;
    logic       b_out_valid, b_isi_valid, b_overrun, b_busy;

    int checks   = 0;
    int failures = 0;
    int rate_exp[$];
    int isi_exp[$];
    int sess_cyc, last_spk;
    bit have_spk;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WIN_BASE(16)) u_dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .en(en), .win_sel(win_sel),
        .rate(rate), .out_valid(out_valid), .out_ready(out_ready),
        .isi(isi), .isi_valid(isi_valid), .overrun(overrun), .busy(busy)
    );

    spike_rate_decoder #(.WIN_BASE(256)) u_big (
        .clk(clk), .rst(rst), .spike_in(b_spike), .en(b_en), .win_sel(2'd0),
        .rate(b_rate), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .isi(b_isi), .isi_valid(b_isi_valid), .overrun(b_overrun), .busy(b_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic s);
        en       = 1'b1;
        spike_in = s;
        have_spk = 1'b0;
        sess_cyc = 0;
        step();
    endtask

    // One COUNT cycle; expected interval is pushed when a spike is issued.
    task automatic cnt_step(input logic s);
        int d;
        spike_in = s;
        if (s) begin
            d = sess_cyc - last_spk;
            if (have_spk) isi_exp.push_back((d > 255) ? 255 : d);
            have_spk = 1'b1;
            last_spk = sess_cyc;
        end
        sess_cyc++;
        step();
    endtask

    // Monitor: sampled on the falling edge, ahead of the rising edge that transfers.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (rate_exp.size() == 0) check("rate_extra", int'(rate), -1);
                else                      check("rate", int'(rate), rate_exp.pop_front());
            end
            if (isi_valid) begin
                if (isi_exp.size() == 0) check("isi_extra", int'(isi), -1);
                else                     check("isi", int'(isi), isi_exp.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; spike_in = 1'b0; win_sel = 2'd0; out_ready = 1'b1;
        b_en = 1'b0; b_spike = 1'b0; b_out_ready = 1'b1;
        sess_cyc = 0; last_spk = 0; have_spk = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_rate", int'(rate), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_isi", int'(isi), 0);
        check("rst_isi_valid", int'(isi_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);

        // Steady rate: spike every 4th cycle, three 16-cycle windows
        win_sel = 2'd0;
        start_session(1'b0);
        check("busy_count", int'(busy), 1);
        for (int k = 0; k < 48; k++) begin
            if (k % 16 == 15) rate_exp.push_back(4);
            cnt_step(k % 4 == 3);
            if (k == 14) check("lat_early", int'(out_valid), 0);
            if (k == 15) check("lat_valid", int'(out_valid), 1);
        end
        en = 1'b0; spike_in = 1'b0; step();
        check("busy_idle", int'(busy), 0);

        // Saturation-size window, spike ignored on entry, mid-window win_sel change
        win_sel = 2'd3;
        rate_exp.push_back(128);
        start_session(1'b1);
        for (int k = 0; k < 128; k++) begin
            cnt_step(1'b1);
            if (k == 5)   win_sel = 2'd0;
            if (k == 126) check("w128_early", int'(out_valid), 0);
            if (k == 127) check("w128_valid", int'(out_valid), 1);
        end
        en = 1'b0; spike_in = 1'b0; step();

        // Backpressure across two window ends: 3 then 5 spikes
        out_ready = 1'b0;
        win_sel   = 2'd0;
        start_session(1'b0);
        for (int k = 0; k < 32; k++) begin
            cnt_step(k inside {0, 5, 10, 16, 18, 20, 22, 24});
            if (k == 15) begin
                check("bp_valid1", int'(out_valid), 1);
                check("bp_rate1", int'(rate), 3);
                check("bp_ovr0", int'(overrun), 0);
            end
        end
        en = 1'b0; spike_in = 1'b0; step();
        check("bp_rate2", int'(rate), 5);
        check("bp_valid2", int'(out_valid), 1);
        check("bp_overrun", int'(overrun), 1);
        rate_exp.push_back(5);
        out_ready = 1'b1;
        step();
        check("bp_drained", int'(out_valid), 0);
        check("bp_ovr_sticky", int'(overrun), 1);

        // Abort at cycle 10 after 2 spikes, then a fresh window
        start_session(1'b0);
        for (int k = 0; k < 10; k++) cnt_step(k == 2 || k == 6);
        en = 1'b0; spike_in = 1'b1; step();
        spike_in = 1'b0;
        repeat (3) step();
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        rate_exp.push_back(1);
        start_session(1'b0);
        for (int k = 0; k < 16; k++) begin
            cnt_step(k == 3);
            if (k == 14) check("fresh_early", int'(out_valid), 0);
            if (k == 15) check("fresh_valid", int'(out_valid), 1);
        end
        en = 1'b0; spike_in = 1'b0; step();

        // Interval of 300 cycles across 19 windows saturates at 255
        for (int w = 0; w < 19; w++) rate_exp.push_back((w == 0 || w == 18) ? 1 : 0);
        start_session(1'b0);
        for (int k = 0; k < 304; k++) cnt_step(k == 0 || k == 300);
        en = 1'b0; spike_in = 1'b0; step();

        // Reset with a pending result and overrun set
        out_ready = 1'b0;
        start_session(1'b0);
        for (int k = 0; k < 16; k++) cnt_step(k == 1 || k == 4);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_ovr", int'(overrun), 1);
        for (int k = 0; k < 5; k++) cnt_step(1'b0);
        rst = 1'b1; spike_in = 1'b1;
        step();
        check("mrst_rate", int'(rate), 0);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_isi", int'(isi), 0);
        check("mrst_isi_valid", int'(isi_valid), 0);
        check("mrst_overrun", int'(overrun), 0);
        check("mrst_busy", int'(busy), 0);
        rst = 1'b0; en = 1'b0; spike_in = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_rate", int'(rate), 0);

        // WIN_BASE=256 instance: 256 spikes must saturate at 255
        b_en = 1'b1;
        step();
        b_spike = 1'b1;
        for (int k = 0; k < 256; k++) begin
            step();
            if (k == 254) check("big_early", int'(b_out_valid), 0);
            if (k == 255) begin
                check("big_valid", int'(b_out_valid), 1);
                check("big_rate", int'(b_rate), 255);
            end
        end
        b_en = 1'b0; b_spike = 1'b0;
        step();
        check("big_drained", int'(b_out_valid), 0);

        repeat (4) step();
        check("rate_pending", rate_exp.size(), 0);
        check("isi_pending", isi_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
